sm4_round_ctrl: RTL and testbench

Iterative SM4 block-cipher engine: accepts one 128-bit block over a valid/ready handshake and runs the 32 SM4 rounds through a single shared round-function instance, one round per clock. It fetches round keys from an external round-key store and returns the 128-bit result over a second valid/ready handshake. It sits between the host datapath and the key store and is the only sequencer of the round function.

---
 rtl/sm4_pkg.sv | 43 ++++
 rtl/x_calculate.sv | 25 ++
 rtl/sm4_round_ctrl.sv | 115 +++++++++++
 tb/tb_sm4_round_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 constants, FSM encoding, S-box table and rotate helper used by
// the round controller and the round-function block.
package sm4_pkg;

    localparam int SM4_ROUNDS  = 32;
    localparam int SM4_WORD_W  = 32;
    localparam int SM4_BLOCK_W = 128;
    localparam int SM4_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sm4_state_e;

    // Block held as four words; index 3 is X0 (the most significant word).
    typedef logic [3:0][SM4_WORD_W-1:0] sm4_block_t;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [SM4_WORD_W-1:0] sm4_rotl(input logic [SM4_WORD_W-1:0] x,
                                                       input int unsigned n);
        return (x << n) | (x >> (SM4_WORD_W - n));
    endfunction

endpackage

// File: rtl/x_calculate.sv
// SM4 round function: x4 = x0 ^ L(tau(x1 ^ x2 ^ x3 ^ rk)), purely combinational.
module x_calculate
    import sm4_pkg::*;
(
    input  logic [SM4_WORD_W-1:0] x0,
    input  logic [SM4_WORD_W-1:0] x1,
    input  logic [SM4_WORD_W-1:0] x2,
    input  logic [SM4_WORD_W-1:0] x3,
    input  logic [SM4_WORD_W-1:0] rk,
    output logic [SM4_WORD_W-1:0] x4
);

    logic [SM4_WORD_W-1:0] t_in;
    logic [SM4_WORD_W-1:0] t_sub;

    assign t_in = x1 ^ x2 ^ x3 ^ rk;

    for (genvar b = 0; b < SM4_WORD_W/8; b++) begin : g_sbox
        assign t_sub[8*b +: 8] = SM4_SBOX[t_in[8*b +: 8]];
    end

    assign x4 = x0 ^ t_sub ^ sm4_rotl(t_sub, 2) ^ sm4_rotl(t_sub, 10)
                   ^ sm4_rotl(t_sub, 18) ^ sm4_rotl(t_sub, 24);

endmodule

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 engine: one round per clock through a shared x_calculate.
// Optional feature: define SM4_CTRL_ABORT_EN to add the abort input.
module sm4_round_ctrl
    import sm4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SM4_BLOCK_W-1:0] in_data,
    input  logic                   in_decrypt,
    output logic [SM4_CNT_W-1:0]   rk_addr,
    input  logic [SM4_WORD_W-1:0]  rk_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SM4_BLOCK_W-1:0] out_data,
    output logic                   busy
`ifdef SM4_CTRL_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam logic [SM4_CNT_W-1:0] LAST_RND = SM4_CNT_W'(SM4_ROUNDS - 1);

    sm4_state_e            state, state_nxt;
    logic [SM4_CNT_W-1:0]  rnd;
    logic                  dec_q;
    sm4_block_t            x_q;
    logic [SM4_WORD_W-1:0] x4;
    logic                  accept, last, abort_hit;

`ifdef SM4_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    x_calculate u_x_calculate (
        .x0 (x_q[3]),
        .x1 (x_q[2]),
        .x2 (x_q[1]),
        .x3 (x_q[0]),
        .rk (rk_data),
        .x4 (x4)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (rnd == LAST_RND) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // 31-r is the bitwise complement for a 5-bit counter.
    assign rk_addr = (state == RUN) ? (dec_q ? ~rnd : rnd) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= '0;
            dec_q     <= 1'b0;
            x_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (abort_hit) begin
                rnd       <= '0;
                x_q       <= '0;
                out_valid <= 1'b0;
            end else begin
                if (accept) begin
                    x_q   <= in_data;
                    dec_q <= in_decrypt;
                    rnd   <= '0;
                end else if (state == RUN) begin
                    x_q <= {x_q[2:0], x4};
                    // Counter parks at the last round until the next accept.
                    if (!last) rnd <= rnd + 1'b1;
                end
                if (last) begin
                    out_data  <= {x4, x_q[0], x_q[1], x_q[2]};
                    out_valid <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Self-checking bench for sm4_round_ctrl: known-answer vectors, random blocks
// and keys against a word-level SM4 model, backpressure, reset and abort.
module tb_sm4_round_ctrl;

    localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam bit [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [4:0]   rk_addr;
    logic [31:0]  rk_data;
    logic [31:0]  rk_mem [32];
    logic         ab_hit;
`ifdef SM4_CTRL_ABORT_EN
    logic         abort;
    assign ab_hit = abort && busy;
`else
    assign ab_hit = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;
    int acc_q [$];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    assign rk_data = rk_mem[rk_addr];

    sm4_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_decrypt (in_decrypt),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef SM4_CTRL_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
    endfunction

    // Standard key schedule (FK/CK constants, L' linear map).
    function automatic void key_sched(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] fk [4];
        logic [31:0] ck, b;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
            b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            rk_mem[i] = k[i+4];
        end
    endfunction

    function automatic logic [127:0] ref_crypt(input logic [127:0] blk, input logic dec);
        logic [31:0] x [36];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk_mem[31-i] : rk_mem[i]));
            x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Scoreboard: every accepted block must come out once, in order, unless discarded.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n || ab_hit) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_crypt(in_data, in_decrypt));
                acc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else chk("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic run_blk(input logic [127:0] blk, input logic dec, input int hold,
                           output logic [127:0] got);
        int t, lat, addr_bad, bp_bad;
        logic [4:0] ea;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk("idle_ready", in_ready, 1);
        in_valid = 1; in_data = blk; in_decrypt = dec; out_ready = 0;
        @(negedge clk);
        in_valid = 0; in_decrypt = ~dec;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat = 0; addr_bad = 0;
        while (!out_valid && lat < 100) begin
            ea = dec ? 5'(31 - lat) : 5'(lat);
            if (rk_addr !== ea || !busy) addr_bad++;
            @(negedge clk); lat++;
        end
        chk("latency", lat, 32);
        chk("rk_addr_seq", addr_bad, 0);
        got = out_data;
        bp_bad = 0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; in_data = ~blk;
            @(negedge clk);
            if (!out_valid || in_ready || out_data !== got) bp_bad++;
        end
        if (hold > 0) chk("backpressure_hold", bp_bad, 0);
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("release_idle", {out_valid, busy, in_ready}, 3'b001);
    endtask

    logic [127:0] got, got2, blk;
    logic         dec;
    int           t, a0, o0, cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; in_decrypt = 0; out_ready = 0;
`ifdef SM4_CTRL_ABORT_EN
        abort = 0;
`endif
        key_sched(PT);
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rk_addr", rk_addr, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1;

        run_blk(PT, 0, 0, got);
        chk("enc_kat", got, CT);
        run_blk(CT, 1, 0, got);
        chk("dec_kat", got, PT);
        run_blk(PT, 0, 10, got);
        chk("bp_kat", got, CT);

        // Back-to-back with in_valid held high and out_ready tied high.
        @(negedge clk);
        a0 = acc_q.size(); o0 = n_out;
        out_ready = 1; in_valid = 1; in_data = PT; in_decrypt = 0;
        t = 0; while (acc_q.size() < a0 + 1 && t < 100) begin @(negedge clk); t++; end
        in_data = CT; in_decrypt = 1;
        t = 0; while (acc_q.size() < a0 + 2 && t < 100) begin @(negedge clk); t++; end
        in_valid = 0;
        t = 0; while (n_out < o0 + 2 && t < 100) begin @(negedge clk); t++; end
        out_ready = 0;
        chk("b2b_accepts", acc_q.size() - a0, 2);
        chk("b2b_outputs", n_out - o0, 2);
        if (acc_q.size() >= a0 + 2) chk("b2b_period", acc_q[a0+1] - acc_q[a0], 34);

        // Reset in the middle of round 15.
        @(negedge clk);
        o0 = n_out;
        in_valid = 1; in_data = PT; in_decrypt = 0;
        @(negedge clk);
        in_valid = 0;
        t = 0; while (rk_addr != 5'd15 && t < 50) begin @(negedge clk); t++; end
        chk("reach_round15", rk_addr, 15);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_state", {out_valid, busy, in_ready, rk_addr}, {3'b001, 5'd0});
        chk("midrst_out_data", out_data, 0);
        out_ready = 1; cnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
        out_ready = 0;
        chk("midrst_no_output", cnt + n_out - o0, 0);
        run_blk(PT, 0, 0, got);
        chk("post_rst_enc", got, CT);

`ifdef SM4_CTRL_ABORT_EN
        @(negedge clk);
        o0 = n_out;
        in_valid = 1; in_data = PT; in_decrypt = 0;
        @(negedge clk);
        in_valid = 0;
        t = 0; while (rk_addr != 5'd20 && t < 50) begin @(negedge clk); t++; end
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_idle", {out_valid, busy, in_ready}, 3'b001);
        out_ready = 1; cnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
        out_ready = 0;
        chk("abort_no_output", cnt + n_out - o0, 0);
        abort = 1; in_valid = 1; in_data = CT; in_decrypt = 1;
        @(negedge clk);
        abort = 0; in_valid = 0;
        chk("abort_idle_ignored", busy, 1);
        t = 0; while (!out_valid && t < 100) begin @(negedge clk); t++; end
        chk("abort_idle_result", out_data, PT);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
`endif

        // Random keys and blocks, each result also decrypted back.
        for (int i = 0; i < 5; i++) begin
            key_sched({$urandom(), $urandom(), $urandom(), $urandom()});
            for (int j = 0; j < 3; j++) begin
                blk = {$urandom(), $urandom(), $urandom(), $urandom()};
                dec = 1'($urandom_range(0, 1));
                run_blk(blk, dec, $urandom_range(0, 3), got);
                chk("rand_model", got, ref_crypt(blk, dec));
                run_blk(got, ~dec, 0, got2);
                chk("rand_roundtrip", got2, blk);
            end
        end

        @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
